rf_writeback: RTL and testbench



---
 rtl/rf_writeback.sv | 121 ++++++++++++
 tb/tb_rf_writeback.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Register-file write initiator: merges pipeline writeback with a
// long-latency result FIFO and tracks registers still owed by that unit.
module rf_writeback #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pipe_valid,
  output logic                       pipe_ready,
  input  logic [4:0]                 pipe_rd,
  input  logic [31:0]                pipe_data,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [4:0]                 lu_rd,
  input  logic [31:0]                lu_data,
  input  logic                       iss_valid,
  input  logic [4:0]                 iss_rd,
  output logic [31:0]                busy_mask,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       rf_we,
  output logic [4:0]                 rf_wreg,
  output logic [31:0]                rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_busy;
  logic          r_we;
  logic [4:0]    r_wreg;
  logic [31:0]   r_wdata;

  logic          w_empty;
  logic          w_full;
  logic          w_starve;
  logic          w_push;
  logic          w_pop;
  logic          w_gnt_pipe;
  logic          w_gnt;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [4:0]    w_gnt_rd;
  logic [31:0]   w_gnt_data;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_starve   = (r_starve == SW'(STARVE_MAX));

  assign lu_ready   = !reset && !w_full;
  assign pipe_ready = !reset && !w_starve;

  assign w_push     = lu_valid && lu_ready;
  assign w_gnt_pipe = pipe_valid && pipe_ready;
  assign w_pop      = !reset && !w_gnt_pipe && !w_empty;
  assign w_gnt      = w_gnt_pipe || w_pop;

  assign w_head_rd   = r_mem_rd[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];
  assign w_gnt_rd    = w_gnt_pipe ? pipe_rd : w_head_rd;
  assign w_gnt_data  = w_gnt_pipe ? pipe_data : w_head_data;

  assign w_set = (iss_valid && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
  assign w_clr = w_pop ? (32'd1 << w_head_rd) : 32'd0;

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= lu_rd;
      r_mem_data[r_wptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_busy   <= '0;
      r_we     <= 1'b0;
      r_wreg   <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
      if (w_pop || w_empty)
        r_starve <= '0;
      else if (w_gnt_pipe && !w_starve)
        r_starve <= r_starve + 1'b1;
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
      r_we   <= w_gnt && (w_gnt_rd != 5'd0);
      if (w_gnt) begin
        r_wreg  <= w_gnt_rd;
        r_wdata <= w_gnt_data;
      end
    end
  end

  assign busy_mask  = r_busy;
  assign fifo_count = r_count;
  assign rf_we      = r_we;
  assign rf_wreg    = r_wreg;
  assign rf_wdata   = r_wdata;

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: queue-based reference model,
// expected writes checked by an independent monitor.
module tb_rf_writeback;

  localparam int DEPTH = 4;
  localparam int SM    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          pipe_valid;
  logic          pipe_ready;
  logic [4:0]    pipe_rd;
  logic [31:0]   pipe_data;
  logic          lu_valid;
  logic          lu_ready;
  logic [4:0]    lu_rd;
  logic [31:0]   lu_data;
  logic          iss_valid;
  logic [4:0]    iss_rd;
  logic [31:0]   busy_mask;
  logic [CW-1:0] fifo_count;
  logic          rf_we;
  logic [4:0]    rf_wreg;
  logic [31:0]   rf_wdata;

  rf_writeback #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_ready (pipe_ready),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .busy_mask  (busy_mask),
    .fifo_count (fifo_count),
    .rf_we      (rf_we),
    .rf_wreg    (rf_wreg),
    .rf_wdata   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  wr_t   exp_q[$];
  ent_t  mq[$];
  int    m_starve;
  bit [31:0]   m_busy;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int    tests;
  int    fails;
  int    cyc;
  int    prdy_low;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_write: got r%0d=%0h expected none (cycle %0d)",
                 rf_wreg, rf_wdata, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e.c));
        chk("wr_reg", 64'(rf_wreg), 64'(e.rd));
        chk("wr_data", 64'(rf_wdata), 64'(e.d));
      end
    end
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      wr_t e;
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missed_write: got none expected r%0d=%0h at cycle %0d",
               e.rd, e.d, e.c);
    end
  end

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_starve = 0;
    m_busy   = '0;
    m_wreg   = '0;
    m_wdata  = '0;
  endtask

  task automatic idle_inputs();
    pipe_valid = 1'b0;
    pipe_rd    = '0;
    pipe_data  = '0;
    lu_valid   = 1'b0;
    lu_rd      = '0;
    lu_data    = '0;
    iss_valid  = 1'b0;
    iss_rd     = '0;
  endtask

  task automatic step(bit pv, logic [4:0] prd, logic [31:0] pd,
                      bit lv, logic [4:0] lrd, logic [31:0] ld,
                      bit iv, logic [4:0] ird);
    bit gp;
    bit pop;
    bit lrdy;
    int n;
    ent_t e;
    @(negedge clk);
    chk("pipe_ready", 64'(pipe_ready), 64'(m_starve != SM));
    chk("lu_ready", 64'(lu_ready), 64'(mq.size() < DEPTH));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("busy_mask", 64'(busy_mask), 64'(m_busy));
    chk("wreg_hold", 64'(rf_wreg), 64'(m_wreg));
    chk("wdata_hold", 64'(rf_wdata), 64'(m_wdata));
    if (pipe_ready === 1'b0) prdy_low++;
    pipe_valid = pv;
    pipe_rd    = prd;
    pipe_data  = pd;
    lu_valid   = lv;
    lu_rd      = lrd;
    lu_data    = ld;
    iss_valid  = iv;
    iss_rd     = ird;
    n    = mq.size();
    gp   = pv && (m_starve != SM);
    lrdy = n < DEPTH;
    pop  = !gp && n > 0;
    if (gp) begin
      m_wreg  = prd;
      m_wdata = pd;
      if (prd != 0) exp_q.push_back('{cyc + 1, prd, pd});
    end else if (pop) begin
      e = mq.pop_front();
      m_wreg  = e.rd;
      m_wdata = e.d;
      if (e.rd != 0) exp_q.push_back('{cyc + 1, e.rd, e.d});
      m_busy[e.rd] = 1'b0;
    end
    if (pop || n == 0) m_starve = 0;
    else if (gp && m_starve < SM) m_starve++;
    if (lv && lrdy) mq.push_back('{lrd, ld});
    if (iv && ird != 0) m_busy[ird] = 1'b1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    model_clear();
    #1;
    chk("rst_pipe_ready", 64'(pipe_ready), 64'd0);
    chk("rst_lu_ready", 64'(lu_ready), 64'd0);
    @(negedge clk);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    reset = 1'b1;
    idle_inputs();
    model_clear();
    do_reset();

    // pipeline write
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle(2);

    // long-latency write clears pending bit
    step(0, 0, 0, 0, 0, 0, 1, 7);
    step(0, 0, 0, 1, 7, 42, 0, 0);
    idle(3);

    // full FIFO blocked by pipeline, starve throttle fires once
    prdy_low = 0;
    for (int i = 0; i < 4; i++)
      step(1, 5'(10 + i), 32'(100 + i), 1, 5'(20 + i), 32'(200 + i), 1, 5'(20 + i));
    for (int i = 0; i < 10; i++)
      step(1, 5'(1 + i), 32'(300 + i), 0, 0, 0, 0, 0);
    chk("starve_once", 64'(prdy_low), 64'd1);
    idle(6);

    // rd==0 results consumed without writing
    step(1, 0, 32'h1111, 1, 0, 32'h2222, 0, 0);
    idle(3);

    // set wins over same-cycle clear
    step(0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 3, 32'h33, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 3);
    idle(2);

    // reset with a partly full FIFO
    for (int i = 0; i < 3; i++)
      step(1, 5'(4 + i), 32'(i), 1, 5'(8 + i), 32'(50 + i), 1, 5'(8 + i));
    do_reset();
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 55, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 99) < 30, 5'($urandom_range(0, 31)));
      end
    end
    idle(DEPTH + 4);
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
